rca_seq_ctrl: RTL and testbench
===============================

// Module: rca_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer that adds two OP_WIDTH-bit operands using one shared 4-bit ripple-carry slice.
//  Each cycle it feeds one 4-bit chunk to the slice, starting at the LSB chunk.
//  It registers the carry between chunks, assembles the OP_WIDTH+1-bit sum and returns it on a valid/ready output.
//  It sits between operand producers and consumers wherever wide adds must reuse the 4-bit adder datapath.
// PARAMETERS
//  OP_WIDTH   16  operand width in bits; must be a multiple of 4 and >= 4
//  NUM_SLICES (localparam) OP_WIDTH/4, the number of ADD cycles per operation
// PORTS
//  clk       in   1            single clock; all state updates on the rising edge
//  rst_n     in   1            reset, asynchronous assert, active-low
//  in_valid  in   1            operand pair offered
//  in_ready  out  1            controller can accept operands
//  term_1    in   OP_WIDTH     operand A
//  term_2    in   OP_WIDTH     operand B
//  out_valid out  1            sum available
//  out_ready in   1            consumer accepts sum
//  sum       out  OP_WIDTH+1   registered result; the MSB is the final carry
//  busy      out  1            high in ADD or DONE
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=IDLE; all operand, sum, carry and index registers cleared.
//   - in_ready=1, out_valid=0, busy=0, sum=0.
//   - An operation in progress is aborted with no output.
//  FSM states:
//   - IDLE: in_ready=1. On in_valid&&in_ready, capture term_1/term_2, set idx=0 and carry=0, go to ADD.
//   - ADD: each cycle, slice inputs are op_a[4*idx+:4], op_b[4*idx+:4] and carry.
//     - sum[4*idx+:4] <= slice sum; carry <= slice carry_out; idx <= idx+1.
//     - When idx==NUM_SLICES-1: sum[OP_WIDTH] <= slice carry_out, go to DONE.
//   - DONE: out_valid=1 and sum is held stable. On out_ready, go to IDLE.
//  Latency and throughput:
//   - Accepting edge E. out_valid rises after edge E+NUM_SLICES.
//   - One operation per NUM_SLICES+2 cycles minimum.
//  Handshake rules:
//   - in_ready=0 in ADD and DONE. in_valid in those states is ignored and no operand is captured.
//   - Operands may change after the accepting edge; only the captured copy is used.
//   - out_valid, once high, stays high with sum unchanged until out_ready is seen.
//   - Simultaneous out_ready and in_valid in DONE: only the output handshake completes. The new input is accepted in IDLE on the next cycle.
//  Width rules:
//   - Unsigned add. sum is OP_WIDTH+1 bits, so no overflow or wrap is possible.
//   - The carry into chunk 0 is always 0.
//  Boundary conditions:
//   - OP_WIDTH=4: a single ADD cycle.
//   - idx is clog2(NUM_SLICES) bits wide (minimum 1) and never exceeds NUM_SLICES-1.
//   - rst_n falling in any state returns to IDLE immediately; a partial sum is never presented.
//  Outputs:
//   - in_ready, out_valid and busy are decoded from registered state only (no combinational in->out paths).
// STRUCTURE
//  Shared package adder_pkg:
//   - SLICE_W=4.
//   - State encoding: enum IDLE/ADD/DONE (2 bits).
//  Sub-module adder_slice_4b:
//   - Four full_adder cells chained with an explicit carry_in port.
//   - Ports: in_1[3:0], in_2[3:0], carry_in, sum_out[3:0], carry_out.
//   - Exactly one instance, driven by the idx mux.
//  This module: FSM, operand/sum/carry/index registers, chunk select mux.
// TESTING
//  1. 0x00F0 + 0x0010 (OP_WIDTH=16): sum=0x00100 with out_valid 4 edges after accept.
//     Confirms carry crossing from chunk 1 into chunk 2.
//  2. 0xFFFF + 0x0001: sum=0x10000 (MSB=1); the carry ripples through all 4 chunks.
//  3. Back-pressure: hold out_ready=0 for 5 cycles after out_valid.
//     sum and out_valid stay stable, in_ready=0, and an in_valid pulse is ignored.
//     Release gives one transfer, then IDLE.
//  4. Reset mid-op: drop rst_n during the 2nd ADD cycle.
//     Outputs reset at once: out_valid=0, sum=0, in_ready=1.
//     A following 0x1234+0x4321 yields 0x05555.
//  5. OP_WIDTH=4: 0xF+0xF gives sum=0x1E one edge after accept.
//     0x0+0x0 gives sum=0x00.
//  6. Back-to-back stream with out_ready=1: 100 random pairs vs a reference model.
//     Each result must match, and consecutive accepts must be exactly NUM_SLICES+2 cycles apart.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the sequenced ripple-carry adder.
//   SLICE_W   : width of the shared adder slice (bits per ADD cycle)
//   state_t   : controller FSM encoding
//   idx_width : width of the chunk index for a given slice count (minimum 1)
package adder_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned idx_width(input int unsigned num_slices);
        return (num_slices > 1) ? $clog2(num_slices) : 1;
    endfunction

endpackage

// File: rtl/adder_slice_4b.sv
// 4-bit ripple-carry adder slice built from four chained full-adder cells.
// Ports:
//   in_1, in_2 : 4-bit addends
//   carry_in   : carry into bit 0
//   sum_out    : 4-bit sum
//   carry_out  : carry out of bit 3
module adder_slice_4b (
    input  logic [3:0] in_1,
    input  logic [3:0] in_2,
    input  logic       carry_in,
    output logic [3:0] sum_out,
    output logic       carry_out
);

    logic [4:0] carry;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < 4; i++) begin : g_full_adder
        assign sum_out[i]   = in_1[i] ^ in_2[i] ^ carry[i];
        assign carry[i + 1] = (in_1[i] & in_2[i]) | (carry[i] & (in_1[i] ^ in_2[i]));
    end

    assign carry_out = carry[4];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle adder: adds two OP_WIDTH-bit operands one 4-bit chunk per cycle
// (LSB chunk first) through a single shared adder_slice_4b, carrying between
// chunks in a register. The OP_WIDTH+1-bit result is offered on a valid/ready port.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (term_1, term_2)
//   out_valid/out_ready : result handshake (sum, MSB is final carry)
//   busy                : operation in flight or result pending
module rca_seq_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned OP_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] term_1,
    input  logic [OP_WIDTH-1:0] term_2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_WIDTH:0]   sum,
    output logic                busy
);

    localparam int unsigned NUM_SLICES = OP_WIDTH / SLICE_W;
    localparam int unsigned IDX_W      = idx_width(NUM_SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_t             state_q, state_d;
    logic [OP_WIDTH-1:0] op_a_q, op_a_d;
    logic [OP_WIDTH-1:0] op_b_q, op_b_d;
    logic [OP_WIDTH:0]   sum_q, sum_d;
    logic                carry_q, carry_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic [SLICE_W-1:0]  slice_a, slice_b, slice_sum;
    logic                slice_co;

    // Chunk select mux feeding the single shared slice.
    assign slice_a = op_a_q[SLICE_W*idx_q +: SLICE_W];
    assign slice_b = op_b_q[SLICE_W*idx_q +: SLICE_W];

    adder_slice_4b u_slice (
        .in_1      (slice_a),
        .in_2      (slice_b),
        .carry_in  (carry_q),
        .sum_out   (slice_sum),
        .carry_out (slice_co)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_a_d  = term_1;
                    op_b_d  = term_2;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[SLICE_W*idx_q +: SLICE_W] = slice_sum;
                carry_d = slice_co;
                if (idx_q == LAST_IDX) begin
                    sum_d[OP_WIDTH] = slice_co;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                // Input handshake is deliberately not considered here.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
module tb_rca_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // 16-bit instance
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] term_1 = '0, term_2 = '0;
    logic        in_ready, out_valid, busy;
    logic [16:0] sum;

    // 4-bit instance
    logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
    logic [3:0]  term_1_4 = '0, term_2_4 = '0;
    logic        in_ready4, out_valid4, busy4;
    logic [4:0]  sum4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rca_seq_ctrl #(.OP_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .term_1    (term_1),
        .term_2    (term_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy)
    );

    rca_seq_ctrl #(.OP_WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .term_1    (term_1_4),
        .term_2    (term_2_4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .busy      (busy4)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Offer operands to the 16-bit DUT and return once the accepting edge has passed (+#1).
    task automatic start16(input logic [15:0] a, input logic [15:0] b, input bit hold_valid);
        int n = 0;
        term_1   = a;
        term_2   = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        accept_cyc = cyc;
        #1;
        if (!hold_valid) in_valid = 1'b0;
    endtask

    // Count edges until out_valid; returns latency in edges from the accepting edge.
    task automatic wait_valid16(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            errors++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic consume16();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int prev_acc;
        logic [16:0] held;

        vecs[0] = '{16'h00F0, 16'h0010, 17'h00100, "chunk1_to_2_carry"};
        vecs[1] = '{16'hFFFF, 16'h0001, 17'h10000, "full_ripple"};
        vecs[2] = '{16'h1234, 16'h4321, 17'h05555, "no_carry"};
        vecs[3] = '{16'h8000, 16'h8000, 17'h10000, "msb_carry_only"};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE, "max_plus_max"};
        vecs[5] = '{16'h0000, 16'h0000, 17'h00000, "zero"};
        vecs[6] = '{16'h0F0F, 16'h00F1, 17'h01000, "alt_carry"};
        vecs[7] = '{16'hABCD, 16'h1111, 17'h0BCDE, "mixed"};

        // Reset state
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_sum4", 32'(sum4), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven directed vectors
        for (int i = 0; i < 8; i++) begin
            start16(vecs[i].a, vecs[i].b, 1'b0);
            check({vecs[i].name, "_busy"}, 32'(busy), 32'd1);
            check({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd0);
            wait_valid16(lat);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'd4);
            check({vecs[i].name, "_sum"}, 32'(sum), 32'(vecs[i].exp));
            consume16();
            check({vecs[i].name, "_idle"}, 32'(in_ready), 32'd1);
        end

        // Back-pressure: result holds for 5 cycles, in_valid pulse ignored
        start16(16'h00F0, 16'h0010, 1'b0);
        wait_valid16(lat);
        held = sum;
        check("bp_sum_first", 32'(held), 32'h00100);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                term_1 = 16'h1111; term_2 = 16'h2222; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum_stable", 32'(sum), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        consume16();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("bp_stays_idle", 32'(busy), 32'd0);

        // Reset during the 2nd ADD cycle
        start16(16'hFFFF, 16'hFFFF, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start16(16'h1234, 16'h4321, 1'b0);
        wait_valid16(lat);
        check("postrst_latency", 32'(lat), 32'd4);
        check("postrst_sum", 32'(sum), 32'h05555);
        consume16();

        // OP_WIDTH=4 instance: single ADD cycle
        term_1_4 = 4'hF; term_2_4 = 4'hF; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        check("w4_busy", 32'(busy4), 32'd1);
        @(posedge clk); #1;
        check("w4_ff_valid", 32'(out_valid4), 32'd1);
        check("w4_ff_sum", 32'(sum4), 32'h1E);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check("w4_idle", 32'(in_ready4), 32'd1);
        term_1_4 = 4'h0; term_2_4 = 4'h0; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        check("w4_00_valid", 32'(out_valid4), 32'd1);
        check("w4_00_sum", 32'(sum4), 32'h00);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;

        // Back-to-back stream, in_valid and out_ready held high
        out_ready = 1'b1;
        prev_acc = -1;
        for (int i = 0; i < 100; i++) begin
            logic [15:0] a, b;
            logic [16:0] exp;
            a = 16'($urandom);
            b = 16'($urandom);
            exp = {1'b0, a} + {1'b0, b};
            start16(a, b, 1'b1);
            if (prev_acc >= 0) check("stream_interval", 32'(accept_cyc - prev_acc), 32'd6);
            prev_acc = accept_cyc;
            wait_valid16(lat);
            check("stream_sum", 32'(sum), 32'(exp));
            // DONE with in_valid also high: only the output handshake completes.
            @(posedge clk); #1;
            check("stream_done_to_idle", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
